// File: rtl/avr_uart_pkg.sv
// Shared types and constants for the AVR I/O-bus UART transmitter.
package avr_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

   localparam int UCSR_TXC   = 7;
   localparam int UCSR_UDRE  = 6;
   localparam int UCSR_DOR   = 5;
   localparam int UCSR_TXEN  = 3;
   localparam int UCSR_TXCIE = 2;
   localparam int UCSR_UDRIE = 1;

   localparam logic [5:0] DEF_UDR_ADR   = 6'h06;
   localparam logic [5:0] DEF_UCSR_ADR  = 6'h07;
   localparam logic [5:0] DEF_UBRRL_ADR = 6'h08;
   localparam logic [5:0] DEF_UBRRH_ADR = 6'h09;
   localparam logic [5:0] DEF_UDRE_VEC  = 6'd19;
   localparam logic [5:0] DEF_TXC_VEC   = 6'd20;

endpackage

// File: rtl/avr_io_uart_tx_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 2,
   parameter int W          = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

   logic [W-1:0]          mem_q [1 << DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
   logic                  do_push, do_pop;

   assign full_o  = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (en_i) begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (en_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/avr_io_uart_tx.sv
// AVR I/O-bus UART transmitter: register decode, 4-deep byte FIFO, baud
// prescaler and 8N1 serialiser with UDRE/TXC interrupt requests.
module avr_io_uart_tx import avr_uart_pkg::*; #(
   parameter logic [5:0] UDR_ADR         = DEF_UDR_ADR,
   parameter logic [5:0] UCSR_ADR        = DEF_UCSR_ADR,
   parameter logic [5:0] UBRRL_ADR       = DEF_UBRRL_ADR,
   parameter logic [5:0] UBRRH_ADR       = DEF_UBRRH_ADR,
   parameter int         FIFO_DEPTH_LOG2 = 2,
   parameter logic [5:0] UDRE_VEC        = DEF_UDRE_VEC,
   parameter logic [5:0] TXC_VEC         = DEF_TXC_VEC
) (
   input  logic       cp2,
   input  logic       ireset,
   input  logic       cp2en,
   input  logic [5:0] adr,
   input  logic       iore,
   input  logic       iowe,
   input  logic [7:0] dbus_in,
   output logic [7:0] dbus_out,
   output logic       out_en,
   output logic       irq_udre,
   output logic       irq_txc,
   input  logic       irqack,
   input  logic [5:0] irqackad,
   output logic       txd
);
   logic sel_udr, sel_ucsr, sel_ubrrl, sel_ubrrh;
   logic wr_udr, wr_ucsr, wr_ubrrl, wr_ubrrh;
   logic fifo_full, fifo_empty, load, tick, bit_end, txc_set;
   logic [7:0] fifo_rdata, ucsr;

   tx_state_e   state_q, state_d;
   logic        txc_q, txc_d, dor_q, dor_d, txen_q, txen_d;
   logic        txcie_q, txcie_d, udrie_q, udrie_d;
   logic [11:0] ubrr_q, ubrr_d, ubrr_act_q, ubrr_act_d, presc_q, presc_d;
   logic [3:0]  tick_cnt_q, tick_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  sh_q, sh_d;

   assign sel_udr   = (adr == UDR_ADR);
   assign sel_ucsr  = (adr == UCSR_ADR);
   assign sel_ubrrl = (adr == UBRRL_ADR);
   assign sel_ubrrh = (adr == UBRRH_ADR);
   assign out_en    = iore & (sel_udr | sel_ucsr | sel_ubrrl | sel_ubrrh);
   assign wr_udr    = iowe & sel_udr;
   assign wr_ucsr   = iowe & sel_ucsr;
   assign wr_ubrrl  = iowe & sel_ubrrl;
   assign wr_ubrrh  = iowe & sel_ubrrh;

   uart_tx_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .W(8)) u_fifo (
      .clk_i   (cp2),
      .rst_i   (ireset),
      .en_i    (cp2en),
      .push_i  (wr_udr),
      .pop_i   (load),
      .wdata_i (dbus_in),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      ucsr             = '0;
      ucsr[UCSR_TXC]   = txc_q;
      ucsr[UCSR_UDRE]  = ~fifo_full;
      ucsr[UCSR_DOR]   = dor_q;
      ucsr[UCSR_TXEN]  = txen_q;
      ucsr[UCSR_TXCIE] = txcie_q;
      ucsr[UCSR_UDRIE] = udrie_q;
   end

   always_comb begin
      dbus_out = 8'h00;
      if (out_en) begin
         if (sel_ucsr)       dbus_out = ucsr;
         else if (sel_ubrrl) dbus_out = ubrr_q[7:0];
         else if (sel_ubrrh) dbus_out = {4'h0, ubrr_q[11:8]};
      end
   end

   assign irq_udre = ucsr[UCSR_UDRE] & udrie_q;
   assign irq_txc  = txc_q & txcie_q;

   // A bit lasts 16 prescaler ticks; a byte is taken from IDLE or straight
   // out of the stop bit so back-to-back frames have no idle gap.
   assign tick    = (presc_q == ubrr_act_q);
   assign bit_end = tick & (tick_cnt_q == 4'hF);
   assign load    = txen_q & ~fifo_empty &
                    ((state_q == IDLE) | ((state_q == STOP) & bit_end));
   assign txc_set = (state_q == STOP) & bit_end & ~load;

   always_ff @(posedge cp2) begin
      if (ireset)     state_q <= IDLE;
      else if (cp2en) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = START;
         START:   if (bit_end) state_d = DATA;
         DATA:    if (bit_end && bit_cnt_q == 3'd7) state_d = STOP;
         STOP:    if (bit_end) state_d = load ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (state_q)
         START:   txd = 1'b0;
         DATA:    txd = sh_q[0];
         default: txd = 1'b1;
      endcase
   end

   always_comb begin
      txc_d   = txc_q;
      dor_d   = dor_q;
      txen_d  = txen_q;
      txcie_d = txcie_q;
      udrie_d = udrie_q;
      ubrr_d  = ubrr_q;
      if (wr_ucsr) begin
         if (dbus_in[UCSR_TXC]) txc_d = 1'b0;
         if (dbus_in[UCSR_DOR]) dor_d = 1'b0;
         txen_d  = dbus_in[UCSR_TXEN];
         txcie_d = dbus_in[UCSR_TXCIE];
         udrie_d = dbus_in[UCSR_UDRIE];
      end
      if (irqack && irqackad == TXC_VEC) txc_d = 1'b0;
      if (txc_set) txc_d = 1'b1;
      if (wr_udr && fifo_full && !load) dor_d = 1'b1;
      if (wr_ubrrl) ubrr_d[7:0]  = dbus_in;
      if (wr_ubrrh) ubrr_d[11:8] = dbus_in[3:0];
   end

   // The divisor in use is only refreshed on a prescaler reload.
   always_comb begin
      presc_d    = presc_q + 12'd1;
      ubrr_act_d = ubrr_act_q;
      if (state_q == IDLE || tick) begin
         presc_d    = '0;
         ubrr_act_d = ubrr_q;
      end
      if (state_q == IDLE) tick_cnt_d = '0;
      else if (tick)       tick_cnt_d = tick_cnt_q + 4'd1;
      else                 tick_cnt_d = tick_cnt_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      if (load) begin
         bit_cnt_d = '0;
         sh_d      = fifo_rdata;
      end else if (state_q == DATA && bit_end) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         sh_d      = {1'b0, sh_q[7:1]};
      end
   end

   always_ff @(posedge cp2) begin
      if (ireset) begin
         txc_q      <= 1'b0;
         dor_q      <= 1'b0;
         txen_q     <= 1'b0;
         txcie_q    <= 1'b0;
         udrie_q    <= 1'b0;
         ubrr_q     <= '0;
         ubrr_act_q <= '0;
         presc_q    <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
      end else if (cp2en) begin
         txc_q      <= txc_d;
         dor_q      <= dor_d;
         txen_q     <= txen_d;
         txcie_q    <= txcie_d;
         udrie_q    <= udrie_d;
         ubrr_q     <= ubrr_d;
         ubrr_act_q <= ubrr_act_d;
         presc_q    <= presc_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
      end
   end

endmodule

// File: tb/tb_avr_io_uart_tx.sv
// Bench for avr_io_uart_tx: bytes written to UDR are queued as expected frames
// and a line receiver checks every enabled-cycle sample of txd against them.
module tb_avr_io_uart_tx;
   localparam logic [5:0] A_UDR = 6'h06, A_UCSR = 6'h07, A_UBRRL = 6'h08, A_UBRRH = 6'h09;
   localparam logic [5:0] V_UDRE = 6'd19, V_TXC = 6'd20;

   logic       cp2 = 1'b0, ireset = 1'b1, cp2en = 1'b1;
   logic [5:0] adr = '0, irqackad = '0;
   logic       iore = 1'b0, iowe = 1'b0, irqack = 1'b0;
   logic [7:0] dbus_in = '0;
   logic [7:0] dbus_out;
   logic       out_en, irq_udre, irq_txc, txd;

   int         checks = 0, errors = 0;
   logic [7:0] exp_q[$];
   int         gap_q[$];
   int         bit_en = 16;
   bit         rx_en = 1'b1, rx_busy = 1'b0, tog = 1'b0;

   avr_io_uart_tx dut (
      .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .adr(adr), .iore(iore), .iowe(iowe),
      .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en), .irq_udre(irq_udre),
      .irq_txc(irq_txc), .irqack(irqack), .irqackad(irqackad), .txd(txd)
   );

   always #5 cp2 = ~cp2;

   initial begin
      forever begin
         @(negedge cp2);
         cp2en = tog ? ~cp2en : 1'b1;
      end
   end

   // Receiver: sample txd after every enabled edge and compare whole frames.
   initial begin
      logic [9:0] bits, pat;
      logic [7:0] e;
      logic       glitch, en, abort;
      int         gap, k, n;
      forever begin
         gap = 0;
         forever begin
            @(posedge cp2); en = cp2en;
            @(negedge cp2);
            if (rx_en && txd === 1'b0 && !ireset) break;
            if (en) gap++;
         end
         rx_busy = 1'b1; bits = '0; glitch = 1'b0; abort = 1'b0;
         n = 10 * bit_en; k = 0;
         bits[0] = txd;
         while (k < n - 1) begin
            @(posedge cp2); en = cp2en;
            if (ireset) begin abort = 1'b1; break; end
            @(negedge cp2);
            if (en) begin
               k++;
               if (k % bit_en == 0) bits[k / bit_en] = txd;
               else if (txd !== bits[k / bit_en]) glitch = 1'b1;
            end
         end
         if (!abort) begin
            gap_q.push_back(gap);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rx_frame: unexpected frame bits=%b", bits);
            end else begin
               e = exp_q.pop_front();
               pat = {1'b1, e, 1'b0};
               if (glitch || bits !== pat) begin
                  errors++;
                  $display("FAIL rx_frame: got %b glitch=%0d, expected %b", bits, glitch, pat);
               end
            end
         end
         rx_busy = 1'b0;
      end
   end

   task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
      @(negedge cp2); adr = a; dbus_in = d; iowe = 1'b1;
      @(negedge cp2); iowe = 1'b0;
   endtask

   task automatic io_rd(input logic [5:0] a, output logic [7:0] d, output logic oe);
      @(negedge cp2); adr = a; iore = 1'b1;
      #1; d = dbus_out; oe = out_en; iore = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      for (t = 0; t < 20000; t++) begin
         @(negedge cp2);
         if (exp_q.size() == 0 && !rx_busy) break;
      end
      if (t == 20000) begin
         checks++; errors++;
         $display("FAIL %s: timeout, %0d frames still expected", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      logic [7:0] d; logic oe;
      ireset = 1'b1;
      repeat (3) @(negedge cp2);
      checks++;
      if ({txd, irq_udre, irq_txc, out_en, dbus_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_outputs: got txd=%b udre=%b txc=%b oe=%b d=%h, expected 1 0 0 0 00",
                  txd, irq_udre, irq_txc, out_en, dbus_out);
      end
      ireset = 1'b0;
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'h40 || oe !== 1'b1) begin errors++; $display("FAIL reset_ucsr: got %h/%b expected 40/1", d, oe); end
      io_rd(A_UBRRH, d, oe); checks++;
      if (d !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL reset_ubrrh: got %h/%b expected 00/1", d, oe); end
      io_wr(A_UBRRH, 8'hFB);
      io_rd(A_UBRRH, d, oe); checks++;
      if (d !== 8'h0B) begin errors++; $display("FAIL ubrrh_rw: got %h expected 0b", d); end
      io_wr(A_UBRRH, 8'h00);
      io_wr(6'h05, 8'hFF);
      io_rd(6'h05, d, oe); checks++;
      if (d !== 8'h00 || oe !== 1'b0) begin errors++; $display("FAIL unmapped_rd: got %h/%b expected 00/0", d, oe); end
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'h40) begin errors++; $display("FAIL unmapped_wr: ucsr got %h expected 40", d); end
      io_rd(A_UDR, d, oe); checks++;
      if (d !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL udr_rd: got %h/%b expected 00/1", d, oe); end
   endtask

   task automatic test_single_frame();
      logic [7:0] d; logic oe;
      io_wr(A_UBRRL, 8'h00);
      io_wr(A_UCSR, 8'h08);
      exp_q.push_back(8'hA5);
      io_wr(A_UDR, 8'hA5);
      wait_idle("single_frame");
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'hC8) begin errors++; $display("FAIL single_txc: ucsr got %h expected c8", d); end
      checks++;
      if (irq_txc !== 1'b0) begin errors++; $display("FAIL irq_txc_masked: got %b expected 0", irq_txc); end
      io_wr(A_UCSR, 8'h0C); checks++;
      if (irq_txc !== 1'b1 || irq_udre !== 1'b0) begin
         errors++; $display("FAIL irq_txc_en: got txc=%b udre=%b expected 1 0", irq_txc, irq_udre);
      end
      io_wr(A_UCSR, 8'h0E); checks++;
      if (irq_udre !== 1'b1) begin errors++; $display("FAIL irq_udre_en: got %b expected 1", irq_udre); end
      io_wr(A_UCSR, 8'h0C);
   endtask

   task automatic test_txc_clear();
      logic [7:0] d; logic oe;
      @(negedge cp2); irqack = 1'b1; irqackad = V_UDRE;
      @(negedge cp2); irqack = 1'b0; checks++;
      if (irq_txc !== 1'b1) begin errors++; $display("FAIL ack_udre_vec: irq_txc got %b expected 1", irq_txc); end
      @(negedge cp2); irqack = 1'b1; irqackad = V_TXC;
      @(negedge cp2); irqack = 1'b0; checks++;
      if (irq_txc !== 1'b0) begin errors++; $display("FAIL ack_txc_vec: irq_txc got %b expected 0", irq_txc); end
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'h4C) begin errors++; $display("FAIL ack_ucsr: got %h expected 4c", d); end
   endtask

   task automatic test_fifo_dor();
      logic [7:0] d; logic oe;
      logic [7:0] data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0] exp_ucsr [5] = '{8'h40, 8'h40, 8'h40, 8'h00, 8'h20};
      io_wr(A_UCSR, 8'h00);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(data[i]);
         io_wr(A_UDR, data[i]);
         io_rd(A_UCSR, d, oe); checks++;
         if (d !== exp_ucsr[i]) begin errors++; $display("FAIL fifo_fill%0d: ucsr got %h expected %h", i, d, exp_ucsr[i]); end
      end
      gap_q.delete();
      io_wr(A_UCSR, 8'h28);
      wait_idle("back_to_back");
      checks++;
      if (gap_q.size() != 4) begin
         errors++; $display("FAIL btb_count: got %0d frames expected 4", gap_q.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (gap_q[i] != 0) begin errors++; $display("FAIL btb_gap%0d: got %0d idle cycles expected 0", i, gap_q[i]); end
         end
      end
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'hC8) begin errors++; $display("FAIL btb_ucsr: got %h expected c8", d); end
   endtask

   task automatic test_txc_w1c_race();
      logic [7:0] d; logic oe;
      io_wr(A_UCSR, 8'h88);
      exp_q.push_back(8'hC3);
      io_wr(A_UDR, 8'hC3);
      repeat (159) @(negedge cp2);
      io_wr(A_UCSR, 8'h88);
      wait_idle("w1c_race");
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'hC8) begin errors++; $display("FAIL txc_set_wins: ucsr got %h expected c8", d); end
      io_wr(A_UCSR, 8'h88);
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'h48) begin errors++; $display("FAIL txc_w1c: ucsr got %h expected 48", d); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d; logic oe; int low;
      exp_q.push_back(8'hC3); exp_q.push_back(8'h99);
      io_wr(A_UDR, 8'hC3);
      io_wr(A_UDR, 8'h99);
      repeat (69) @(negedge cp2);
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL midframe_bit3: txd got %b expected 0", txd); end
      ireset = 1'b1;
      @(negedge cp2); checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
      ireset = 1'b0;
      exp_q.delete();
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'h40) begin errors++; $display("FAIL reset_mid_ucsr: got %h expected 40", d); end
      io_wr(A_UCSR, 8'h08);
      low = 0;
      repeat (300) begin @(negedge cp2); if (txd !== 1'b1) low++; end
      checks++;
      if (low != 0) begin errors++; $display("FAIL reset_fifo_empty: txd low for %0d cycles expected 0", low); end
   endtask

   task automatic test_cp2en_toggle();
      logic [7:0] d; logic oe;
      io_wr(A_UBRRL, 8'h02);
      bit_en = 48;
      exp_q.push_back(8'h5A);
      io_wr(A_UDR, 8'h5A);
      tog = 1'b1;
      wait_idle("cp2en_toggle");
      tog = 1'b0;
      bit_en = 16;
      io_rd(A_UCSR, d, oe); checks++;
      if (d !== 8'hC8) begin errors++; $display("FAIL toggle_ucsr: got %h expected c8", d); end
   endtask

   task automatic test_ubrr_midframe();
      logic [7:0] d; logic oe; int cnt, t;
      rx_en = 1'b0;
      io_wr(A_UCSR, 8'h88);
      io_wr(A_UDR, 8'hA5);
      for (t = 0; t < 50 && txd !== 1'b0; t++) @(negedge cp2);
      repeat (3) @(negedge cp2);
      io_wr(A_UBRRL, 8'h00);
      cnt = 5;
      for (t = 0; t < 200 && txd === 1'b0; t++) begin @(negedge cp2); cnt++; end
      checks++;
      if (cnt != 20) begin errors++; $display("FAIL ubrr_reload: start bit %0d cycles expected 20", cnt); end
      for (t = 0; t < 2000; t++) begin
         io_rd(A_UCSR, d, oe);
         if (d[7]) break;
      end
      checks++;
      if (d !== 8'hC8) begin errors++; $display("FAIL ubrr_frame_end: ucsr got %h expected c8", d); end
      rx_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_txc_clear();
      test_fifo_dor();
      test_txc_w1c_race();
      test_reset_midframe();
      test_cp2en_toggle();
      test_ubrr_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
